// File: rtl/mem_port_arbiter_if.sv
// Bundle between the two custom-instruction requesters, the arbiter and the
// single-port coprocessor RAM.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              done0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_q,
        output done0, done1, rdata, busy, mem_address, mem_data, mem_wren
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_q,
        input  done0, done1, rdata, busy, mem_address, mem_data, mem_wren
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and access sequencer for one single-port RAM shared by
// two requesters; every output comes straight from a register.
//   state  | meaning
//   IDLE   | waiting for a request; arbitration happens on the leaving edge
//   ACCESS | write strobe cycle, or counting down the read latency
//   DONE   | completion pulse to the owner; last_owner updated on exit
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nx;
    logic              owner, owner_nx;
    logic              we_r, we_nx;
    logic              last_owner, last_owner_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              done0_q, done0_nx;
    logic              done1_q, done1_nx;
    logic              busy_q, busy_nx;
    logic              wren_q, wren_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [DATA_W-1:0] data_q, data_nx;
    logic [DATA_W-1:0] rdata_q, rdata_nx;
    logic              win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            we_r       <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            busy_q     <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            we_r       <= we_nx;
            last_owner <= last_owner_nx;
            cnt        <= cnt_nx;
            done0_q    <= done0_nx;
            done1_q    <= done1_nx;
            busy_q     <= busy_nx;
            wren_q     <= wren_nx;
            addr_q     <= addr_nx;
            data_q     <= data_nx;
            rdata_q    <= rdata_nx;
        end
    end

    // Requester 1 wins when alone, or when both ask and 0 went last.
    assign win = bus.req1 & (~bus.req0 | ~last_owner);

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        we_nx         = we_r;
        last_owner_nx = last_owner;
        cnt_nx        = cnt;
        done0_nx      = done0_q;
        done1_nx      = done1_q;
        busy_nx       = busy_q;
        wren_nx       = wren_q;
        addr_nx       = addr_q;
        data_nx       = data_q;
        rdata_nx      = rdata_q;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_nx = win;
                    we_nx    = win ? bus.we1 : bus.we0;
                    wren_nx  = win ? bus.we1 : bus.we0;
                    addr_nx  = win ? bus.addr1 : bus.addr0;
                    data_nx  = win ? bus.wdata1 : bus.wdata0;
                    cnt_nx   = CNT_W'(RD_LATENCY - 1);
                    busy_nx  = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (we_r || cnt == '0) begin
                    wren_nx  = 1'b0;
                    done0_nx = ~owner;
                    done1_nx = owner;
                    state_nx = DONE;
                    if (!we_r) rdata_nx = bus.mem_q;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                done0_nx      = 1'b0;
                done1_nx      = 1'b0;
                last_owner_nx = owner;
                busy_nx       = 1'b0;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.done0       = done0_q;
    assign bus.done1       = done1_q;
    assign bus.rdata       = rdata_q;
    assign bus.busy        = busy_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_data    = data_q;
    assign bus.mem_wren    = wren_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance a uses RD_LATENCY=2,
// instance b uses RD_LATENCY=1, each with its own behavioural RAM.
module tb_mem_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    // RAM a: one output register stage plus the arbiter's address register = 2 cycles
    logic [DW-1:0] ram_a [0:(1<<AW)-1];
    logic [DW-1:0] q_a;
    always @(posedge clk) begin
        if (ifa.mem_wren) ram_a[ifa.mem_address] <= ifa.mem_data;
        q_a <= ram_a[ifa.mem_address];
    end
    assign ifa.mem_q = q_a;

    // RAM b: asynchronous read, data valid one cycle after the address register
    logic [DW-1:0] ram_b [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ifb.mem_wren) ram_b[ifb.mem_address] <= ifb.mem_data;
    end
    assign ifb.mem_q = ram_b[ifb.mem_address];

    typedef struct packed {logic id; logic rd; logic [DW-1:0] data;} done_t;
    typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;

    done_t exp_done_a[$];
    done_t exp_done_b[$];
    wr_t   exp_wr_a[$];
    wr_t   exp_wr_b[$];

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input bit sel, input bit id, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rexp);
        done_t d;
        wr_t   w;
        d.id = id;
        d.rd = ~we;
        d.data = we ? '0 : rexp;
        w.addr = addr;
        w.data = wdata;
        if (sel) begin
            exp_done_b.push_back(d);
            if (we) exp_wr_b.push_back(w);
        end else begin
            exp_done_a.push_back(d);
            if (we) exp_wr_a.push_back(w);
        end
    endtask

    task automatic mon(input bit sel);
        logic d0, d1, wren;
        logic [DW-1:0] rd;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        done_t e;
        wr_t   w;
        d0   = sel ? ifb.done0 : ifa.done0;
        d1   = sel ? ifb.done1 : ifa.done1;
        wren = sel ? ifb.mem_wren : ifa.mem_wren;
        rd   = sel ? ifb.rdata : ifa.rdata;
        ma   = sel ? ifb.mem_address : ifa.mem_address;
        md   = sel ? ifb.mem_data : ifa.mem_data;
        if (d0 || d1) begin
            check(sel ? "b_done_one_hot" : "a_done_one_hot", 64'(d0 & d1), 64'(0));
            check(sel ? "b_done_expected" : "a_done_expected",
                  64'((sel ? exp_done_b.size() : exp_done_a.size()) != 0), 64'(1));
            if ((sel ? exp_done_b.size() : exp_done_a.size()) != 0) begin
                e = sel ? exp_done_b.pop_front() : exp_done_a.pop_front();
                check(sel ? "b_done_id" : "a_done_id", 64'(d1), 64'(e.id));
                if (e.rd) check(sel ? "b_rdata" : "a_rdata", 64'(rd), 64'(e.data));
            end
        end
        if (wren) begin
            check(sel ? "b_wren_expected" : "a_wren_expected",
                  64'((sel ? exp_wr_b.size() : exp_wr_a.size()) != 0), 64'(1));
            if ((sel ? exp_wr_b.size() : exp_wr_a.size()) != 0) begin
                w = sel ? exp_wr_b.pop_front() : exp_wr_a.pop_front();
                check(sel ? "b_wr_addr" : "a_wr_addr", 64'(ma), 64'(w.addr));
                check(sel ? "b_wr_data" : "a_wr_data", 64'(md), 64'(w.data));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0);
        mon(1'b1);
    end

    // Waits for n0/n1 done pulses, dropping each req once its count is reached.
    task automatic run(input bit sel, input int n0, input int n1, output int lat, output int gap);
        int c0 = 0;
        int c1 = 0;
        int i = 0;
        int last = -1;
        logic d0, d1;
        lat = -1;
        gap = 0;
        while ((c0 < n0 || c1 < n1) && i < 100) begin
            @(negedge clk);
            i++;
            d0 = sel ? ifb.done0 : ifa.done0;
            d1 = sel ? ifb.done1 : ifa.done1;
            if (d0 || d1) begin
                if (lat < 0) lat = i;
                if (last >= 0 && i - last > gap) gap = i - last;
                last = i;
            end
            if (d0) begin
                c0++;
                if (c0 >= n0) begin if (sel) ifb.req0 = 1'b0; else ifa.req0 = 1'b0; end
            end
            if (d1) begin
                c1++;
                if (c1 >= n1) begin if (sel) ifb.req1 = 1'b0; else ifa.req1 = 1'b0; end
            end
        end
        check("run_complete", 64'(c0 >= n0 && c1 >= n1), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, gap;
        ifa.req0 = 0; ifa.we0 = 0; ifa.addr0 = '0; ifa.wdata0 = '0;
        ifa.req1 = 0; ifa.we1 = 0; ifa.addr1 = '0; ifa.wdata1 = '0;
        ifb.req0 = 0; ifb.we0 = 0; ifb.addr0 = '0; ifb.wdata0 = '0;
        ifb.req1 = 0; ifb.we1 = 0; ifb.addr1 = '0; ifb.wdata1 = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  64'(ifa.busy), 64'(0));
        check("rst_done0", 64'(ifa.done0), 64'(0));
        check("rst_done1", 64'(ifa.done1), 64'(0));
        check("rst_wren",  64'(ifa.mem_wren), 64'(0));
        check("rst_addr",  64'(ifa.mem_address), 64'(0));
        check("rst_data",  64'(ifa.mem_data), 64'(0));
        check("rst_rdata", 64'(ifa.rdata), 64'(0));
        reset = 1'b1;

        // single write from requester 0
        push(0, 0, 1, 10'd5, 32'hDEADBEEF, '0);
        ifa.we0 = 1; ifa.addr0 = 10'd5; ifa.wdata0 = 32'hDEADBEEF; ifa.req0 = 1;
        run(0, 1, 0, lat, gap);
        check("t1_write_latency", 64'(lat), 64'(2));
        @(negedge clk);
        check("t1_busy_after", 64'(ifa.busy), 64'(0));

        // preload addr 7, then requester 1 reads it back
        push(0, 0, 1, 10'd7, 32'h12345678, '0);
        ifa.we0 = 1; ifa.addr0 = 10'd7; ifa.wdata0 = 32'h12345678; ifa.req0 = 1;
        run(0, 1, 0, lat, gap);
        @(negedge clk);
        push(0, 1, 0, 10'd7, '0, 32'h12345678);
        ifa.we1 = 0; ifa.addr1 = 10'd7; ifa.req1 = 1;
        @(negedge clk);
        check("t2_read_addr", 64'(ifa.mem_address), 64'(7));
        @(negedge clk);
        check("t2_read_addr_held", 64'(ifa.mem_address), 64'(7));
        run(0, 0, 1, lat, gap);
        check("t2_read_latency", 64'(lat + 2), 64'(3));

        // both requesters from reset: 0,1,0,1 with no extra gap
        reset = 1'b0;
        ifa.we0 = 1; ifa.addr0 = 10'd1; ifa.wdata0 = 32'h11110001;
        ifa.we1 = 1; ifa.addr1 = 10'd2; ifa.wdata1 = 32'h22220002;
        ifa.req0 = 1; ifa.req1 = 1;
        for (int r = 0; r < 2; r++) begin
            push(0, 0, 1, 10'd1, 32'h11110001, '0);
            push(0, 1, 1, 10'd2, 32'h22220002, '0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run(0, 2, 2, lat, gap);
        check("t3_first_latency", 64'(lat), 64'(2));
        check("t3_gap", 64'(gap), 64'(3));
        check("t3_rdata_cleared", 64'(ifa.rdata), 64'(0));

        // requester 1 holds req; requester 0 cuts in once
        @(negedge clk);
        push(0, 1, 1, 10'd3, 32'h33330003, '0);
        push(0, 0, 1, 10'd4, 32'h44440004, '0);
        push(0, 1, 1, 10'd3, 32'h33330003, '0);
        ifa.we1 = 1; ifa.addr1 = 10'd3; ifa.wdata1 = 32'h33330003; ifa.req1 = 1;
        @(negedge clk);
        check("t4_busy", 64'(ifa.busy), 64'(1));
        ifa.we0 = 1; ifa.addr0 = 10'd4; ifa.wdata0 = 32'h44440004; ifa.req0 = 1;
        run(0, 1, 2, lat, gap);
        check("t4_gap", 64'(gap), 64'(3));

        // leave last_owner=0, then abort a write with reset
        @(negedge clk);
        push(0, 0, 1, 10'd8, 32'h88880008, '0);
        ifa.we0 = 1; ifa.addr0 = 10'd8; ifa.wdata0 = 32'h88880008; ifa.req0 = 1;
        run(0, 1, 0, lat, gap);
        @(negedge clk);
        ifa.we0 = 1; ifa.addr0 = 10'd9; ifa.wdata0 = 32'h99990009; ifa.req0 = 1;
        @(posedge clk);
        #2;
        check("t5_wren_before", 64'(ifa.mem_wren), 64'(1));
        reset = 1'b0;
        #1;
        check("t5_wren_async", 64'(ifa.mem_wren), 64'(0));
        check("t5_busy_async", 64'(ifa.busy), 64'(0));
        check("t5_addr_async", 64'(ifa.mem_address), 64'(0));
        ifa.req0 = 0;
        @(negedge clk);
        check("t5_no_done", 64'(ifa.done0), 64'(0));
        ifa.we0 = 1; ifa.addr0 = 10'd10; ifa.wdata0 = 32'hAAAA000A; ifa.req0 = 1;
        ifa.we1 = 1; ifa.addr1 = 10'd11; ifa.wdata1 = 32'hBBBB000B; ifa.req1 = 1;
        push(0, 0, 1, 10'd10, 32'hAAAA000A, '0);
        push(0, 1, 1, 10'd11, 32'hBBBB000B, '0);
        @(negedge clk);
        reset = 1'b1;
        run(0, 1, 1, lat, gap);
        check("t5_post_reset_latency", 64'(lat), 64'(2));

        // RD_LATENCY=1: read then write to the same address
        @(negedge clk);
        push(1, 1, 1, 10'd20, 32'hA5A50001, '0);
        ifb.we1 = 1; ifb.addr1 = 10'd20; ifb.wdata1 = 32'hA5A50001; ifb.req1 = 1;
        run(1, 0, 1, lat, gap);
        @(negedge clk);
        push(1, 0, 0, 10'd20, '0, 32'hA5A50001);
        push(1, 1, 1, 10'd20, 32'h5A5A0002, '0);
        ifb.we0 = 0; ifb.addr0 = 10'd20; ifb.req0 = 1;
        ifb.we1 = 1; ifb.addr1 = 10'd20; ifb.wdata1 = 32'h5A5A0002; ifb.req1 = 1;
        run(1, 1, 1, lat, gap);
        check("t6_read_latency", 64'(lat), 64'(2));
        check("t6_gap", 64'(gap), 64'(3));
        @(negedge clk);
        check("t6_rdata_held", 64'(ifb.rdata), 64'(32'hA5A50001));

        repeat (3) @(negedge clk);
        check("a_done_queue_empty", 64'(exp_done_a.size()), 64'(0));
        check("a_wr_queue_empty",   64'(exp_wr_a.size()), 64'(0));
        check("b_done_queue_empty", 64'(exp_done_b.size()), 64'(0));
        check("b_wr_queue_empty",   64'(exp_wr_b.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
